// File: rtl/bus_dev_fifo_bank.sv
// Generic show-ahead FIFO used for both directions of every bank channel.
// Latency: a write at edge N is visible at the head from N+1; reads retire the head on the edge.
// Backpressure: none upstream; when full a write is dropped, or overwrites the oldest entry if overwrite=1.
module bus_dev_fifo_bank_fifo #(
  parameter int width     = 16,
  parameter int depth     = 8,
  parameter bit overwrite = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] wdata,
  input  logic             rd,
  output logic             vld,
  output logic [width-1:0] head,
  output logic             full
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_lvl = (aw+1)'(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    rptr, wptr;
  logic [aw:0]      cnt;
  logic             rd_ok, wr_ok, ovw, grow;

  // Accept/retire decisions; a full FIFO still accepts a write when the head leaves on the same edge.
  always_comb begin
    vld   = (cnt != '0);
    full  = (cnt == full_lvl);
    rd_ok = rd && vld;
    ovw   = overwrite && wr && full && !rd_ok;
    wr_ok = wr && (!full || rd_ok || overwrite);
    grow  = wr_ok && !ovw;
    head  = vld ? mem[rptr] : '0;
  end

  // Pointer and occupancy state; overwrite advances both pointers and keeps the count at depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok)          wptr <= wptr + aw'(1);
      if (rd_ok || ovw)   rptr <= rptr + aw'(1);
      if (grow && !rd_ok) cnt  <= cnt + (aw+1)'(1);
      else if (rd_ok && !grow) cnt <= cnt - (aw+1)'(1);
    end
  end

  // Storage is intentionally not reset; the empty flag masks stale contents at the head.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end
endmodule

// Per-device FIFO bank: ingress (agent->bus) and egress (bus->monitor) FIFO per channel, misroute flag, drop counter.
// Latency: one cycle from write/push to pndng/out_vld and head data; sustains one packet per cycle per FIFO.
// Backpressure: none; full ingress drops or overwrites per ovf_mode, full egress drops new, drops are counted.
module bus_dev_fifo_bank #(
  parameter int         bits      = 1,
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter int         ovf_mode  = 0
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [bits-1:0][drvrs-1:0]               in_wr,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  in_data,
  output logic [bits-1:0][drvrs-1:0]               in_full,
  output logic [bits-1:0][drvrs-1:0]               pndng,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
  input  logic [bits-1:0][drvrs-1:0]               pop,
  input  logic [bits-1:0][drvrs-1:0]               push,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push,
  output logic [bits-1:0][drvrs-1:0]               out_vld,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  out_data,
  input  logic [bits-1:0][drvrs-1:0]               out_rd,
  output logic [bits-1:0][drvrs-1:0]               misroute,
  output logic [bits-1:0][drvrs-1:0][7:0]          drop_cnt
);
  for (genvar b = 0; b < bits; b++) begin : gen_bus
    for (genvar d = 0; d < drvrs; d++) begin : gen_dev
      logic       eg_full;
      logic       in_drop, eg_drop, mis_hit, mis_q;
      logic [7:0] dest, drp_q;
      logic [8:0] drp_sum;

      bus_dev_fifo_bank_fifo #(
        .width(pckg_sz), .depth(depth), .overwrite(ovf_mode != 0)
      ) u_ingress (
        .clk(clk), .reset(reset),
        .wr(in_wr[b][d]), .wdata(in_data[b][d]), .rd(pop[b][d]),
        .vld(pndng[b][d]), .head(D_pop[b][d]), .full(in_full[b][d])
      );

      bus_dev_fifo_bank_fifo #(
        .width(pckg_sz), .depth(depth), .overwrite(1'b0)
      ) u_egress (
        .clk(clk), .reset(reset),
        .wr(push[b][d]), .wdata(D_push[b][d]), .rd(out_rd[b][d]),
        .vld(out_vld[b][d]), .head(out_data[b][d]), .full(eg_full)
      );

      // Drop/misroute detection; an overwrite also counts as a drop since the oldest packet is lost.
      always_comb begin
        in_drop = in_wr[b][d] && in_full[b][d] && !(pop[b][d] && pndng[b][d]);
        eg_drop = push[b][d] && eg_full && !(out_rd[b][d] && out_vld[b][d]);
        dest    = D_push[b][d][pckg_sz-1 -: 8];
        mis_hit = push[b][d] && (dest != 8'(d)) && (dest != broadcast);
        drp_sum = {1'b0, drp_q} + 9'(in_drop) + 9'(eg_drop);
      end

      // Sticky misroute flag and shared saturating drop counter.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          mis_q <= 1'b0;
          drp_q <= '0;
        end else begin
          if (mis_hit) mis_q <= 1'b1;
          drp_q <= drp_sum[8] ? 8'hFF : drp_sum[7:0];
        end
      end

      assign misroute[b][d] = mis_q;
      assign drop_cnt[b][d] = drp_q;
    end
  end
endmodule

// File: tb/tb_bus_dev_fifo_bank.sv
module tb_bus_dev_fifo_bank;
  localparam int B = 1, D = 4, W = 16, DEP = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [B-1:0][D-1:0]         in_wr, pop, push, out_rd;
  logic [B-1:0][D-1:0][W-1:0]  in_data, D_push;
  logic [B-1:0][D-1:0]         in_full_o [2], pndng_o [2], out_vld_o [2], misroute_o [2];
  logic [B-1:0][D-1:0][W-1:0]  D_pop_o [2], out_data_o [2];
  logic [B-1:0][D-1:0][7:0]    drop_o [2];

  int tests = 0;
  int fails = 0;

  // Reference model: index 0 = drop-new instance, 1 = overwrite-oldest instance.
  logic [W-1:0] ing_q [2][D][$];
  logic [W-1:0] egr_q [2][D][$];
  bit           mis_m [2][D];
  int           drp_m [2][D];

  always #5 clk = ~clk;

  bus_dev_fifo_bank #(.bits(B), .drvrs(D), .pckg_sz(W), .depth(DEP), .broadcast(8'hFF), .ovf_mode(0)) dut0 (
    .clk(clk), .reset(reset), .in_wr(in_wr), .in_data(in_data), .in_full(in_full_o[0]),
    .pndng(pndng_o[0]), .D_pop(D_pop_o[0]), .pop(pop), .push(push), .D_push(D_push),
    .out_vld(out_vld_o[0]), .out_data(out_data_o[0]), .out_rd(out_rd),
    .misroute(misroute_o[0]), .drop_cnt(drop_o[0]));

  bus_dev_fifo_bank #(.bits(B), .drvrs(D), .pckg_sz(W), .depth(DEP), .broadcast(8'hFF), .ovf_mode(1)) dut1 (
    .clk(clk), .reset(reset), .in_wr(in_wr), .in_data(in_data), .in_full(in_full_o[1]),
    .pndng(pndng_o[1]), .D_pop(D_pop_o[1]), .pop(pop), .push(push), .D_push(D_push),
    .out_vld(out_vld_o[1]), .out_data(out_data_o[1]), .out_rd(out_rd),
    .misroute(misroute_o[1]), .drop_cnt(drop_o[1]));

  task automatic model_apply();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < D; c++) begin
        int inc;
        bit full, rok;
        logic [7:0] dst;
        inc  = 0;
        full = (ing_q[m][c].size() == DEP);
        rok  = pop[0][c] && (ing_q[m][c].size() != 0);
        if (rok) void'(ing_q[m][c].pop_front());
        if (in_wr[0][c]) begin
          if (!full || rok) ing_q[m][c].push_back(in_data[0][c]);
          else begin
            inc++;
            if (m == 1) begin
              void'(ing_q[m][c].pop_front());
              ing_q[m][c].push_back(in_data[0][c]);
            end
          end
        end
        full = (egr_q[m][c].size() == DEP);
        rok  = out_rd[0][c] && (egr_q[m][c].size() != 0);
        if (rok) void'(egr_q[m][c].pop_front());
        if (push[0][c]) begin
          if (!full || rok) egr_q[m][c].push_back(D_push[0][c]);
          else inc++;
        end
        dst = D_push[0][c][W-1 -: 8];
        if (push[0][c] && dst != 8'(c) && dst != 8'hFF) mis_m[m][c] = 1'b1;
        drp_m[m][c] = (drp_m[m][c] + inc > 255) ? 255 : drp_m[m][c] + inc;
      end
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < D; c++) begin
        ing_q[m][c].delete();
        egr_q[m][c].delete();
        mis_m[m][c] = 1'b0;
        drp_m[m][c] = 0;
      end
  endtask

  task automatic clear_strobes();
    in_wr = '0; pop = '0; push = '0; out_rd = '0;
  endtask

  // One clock: model consumes the inputs present at the edge, outputs are observed 1 time unit later.
  task automatic step();
    model_apply();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      tests++;
      if ({pndng_o[m], out_vld_o[m], in_full_o[m], misroute_o[m]} !== '0) begin
        fails++; $display("FAIL reset_flags m%0d got %h want 0", m, {pndng_o[m], out_vld_o[m], in_full_o[m], misroute_o[m]});
      end
      tests++;
      if (drop_o[m] !== '0) begin
        fails++; $display("FAIL reset_drop m%0d got %h want 0", m, drop_o[m]);
      end
      tests++;
      if ({D_pop_o[m], out_data_o[m]} !== '0) begin
        fails++; $display("FAIL reset_data m%0d got %h want 0", m, {D_pop_o[m], out_data_o[m]});
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    in_wr[0][1] = 1'b1; in_data[0][1] = 16'h0155;
    step();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (pndng_o[m][0][1] !== 1'b1 || D_pop_o[m][0][1] !== 16'h0155) begin
        fails++; $display("FAIL basic_write m%0d got pndng=%b D_pop=%h want 1/0155", m, pndng_o[m][0][1], D_pop_o[m][0][1]);
      end
    end
    pop[0][1] = 1'b1;
    step();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (pndng_o[m][0][1] !== 1'b0 || D_pop_o[m][0][1] !== 16'h0000) begin
        fails++; $display("FAIL basic_pop m%0d got pndng=%b D_pop=%h want 0/0000", m, pndng_o[m][0][1], D_pop_o[m][0][1]);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      in_wr[0][0] = 1'b1; in_data[0][0] = 16'(i + 1);
      step();
    end
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (in_full_o[m][0][0] !== 1'b1 || drop_o[m][0][0] !== 8'd1) begin
        fails++; $display("FAIL ovf_full m%0d got full=%b drop=%0d want 1/1", m, in_full_o[m][0][0], drop_o[m][0][0]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (D_pop_o[0][0][0] !== 16'(i + 1)) begin
        fails++; $display("FAIL ovf0_order idx%0d got %h want %h", i, D_pop_o[0][0][0], 16'(i + 1));
      end
      tests++;
      if (D_pop_o[1][0][0] !== 16'(i + 2)) begin
        fails++; $display("FAIL ovf1_order idx%0d got %h want %h", i, D_pop_o[1][0][0], 16'(i + 2));
      end
      pop[0][0] = 1'b1;
      step();
    end
    tests++;
    if (pndng_o[0][0][0] !== 1'b0 || pndng_o[1][0][0] !== 1'b0) begin
      fails++; $display("FAIL ovf_drained got %b%b want 00", pndng_o[0][0][0], pndng_o[1][0][0]);
    end
  endtask

  task automatic test_misroute();
    push[0][2] = 1'b1; D_push[0][2] = 16'h03AA;
    step();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (misroute_o[m][0][2] !== 1'b1 || out_data_o[m][0][2] !== 16'h03AA) begin
        fails++; $display("FAIL misroute_set m%0d got mis=%b data=%h want 1/03AA", m, misroute_o[m][0][2], out_data_o[m][0][2]);
      end
    end
    push[0][3] = 1'b1; D_push[0][3] = 16'hFF11;
    step();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (misroute_o[m][0][3] !== 1'b0 || out_data_o[m][0][3] !== 16'hFF11) begin
        fails++; $display("FAIL misroute_bcast m%0d got mis=%b data=%h want 0/FF11", m, misroute_o[m][0][3], out_data_o[m][0][3]);
      end
    end
    out_rd[0][2] = 1'b1; out_rd[0][3] = 1'b1;
    step();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (out_vld_o[m][0][3:2] !== 2'b00 || misroute_o[m][0][2] !== 1'b1) begin
        fails++; $display("FAIL misroute_drain m%0d got vld=%b mis=%b want 00/1", m, out_vld_o[m][0][3:2], misroute_o[m][0][2]);
      end
    end
  endtask

  task automatic test_dual_drop();
    for (int i = 0; i < 8; i++) begin
      in_wr[0][2] = 1'b1; in_data[0][2] = 16'(16'hA0 + i);
      push[0][2]  = 1'b1; D_push[0][2]  = 16'(16'h0200 + i);
      step();
    end
    in_wr[0][2] = 1'b1; in_data[0][2] = 16'h00BB;
    push[0][2]  = 1'b1; D_push[0][2]  = 16'h02CC;
    step();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (drop_o[m][0][2] !== 8'd2 || in_full_o[m][0][2] !== 1'b1) begin
        fails++; $display("FAIL dual_drop m%0d got drop=%0d full=%b want 2/1", m, drop_o[m][0][2], in_full_o[m][0][2]);
      end
      tests++;
      if (out_data_o[m][0][2] !== 16'h0200) begin
        fails++; $display("FAIL dual_drop_egress_head m%0d got %h want 0200", m, out_data_o[m][0][2]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      pop[0][2] = 1'b1; out_rd[0][2] = 1'b1;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q [$];
    for (int i = 0; i < 8; i++) begin
      push[0][1] = 1'b1; D_push[0][1] = {8'h01, 8'(i)};
      exp_q.push_back({8'h01, 8'(i)});
      step();
    end
    for (int k = 0; k < 20; k++) begin
      for (int m = 0; m < 2; m++) begin
        tests++;
        if (out_vld_o[m][0][1] !== 1'b1 || out_data_o[m][0][1] !== exp_q[0]) begin
          fails++; $display("FAIL b2b_order m%0d cyc%0d got vld=%b data=%h want 1/%h", m, k, out_vld_o[m][0][1], out_data_o[m][0][1], exp_q[0]);
        end
      end
      push[0][1] = 1'b1; out_rd[0][1] = 1'b1; D_push[0][1] = {8'h01, 8'(8 + k)};
      void'(exp_q.pop_front());
      exp_q.push_back({8'h01, 8'(8 + k)});
      step();
    end
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (drop_o[m][0][1] !== 8'd0) begin
        fails++; $display("FAIL b2b_nodrop m%0d got %0d want 0", m, drop_o[m][0][1]);
      end
    end
    for (int k = 0; k < 300; k++) begin
      push[0][1] = 1'b1; D_push[0][1] = {8'h01, 8'($urandom)};
      step();
    end
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (drop_o[m][0][1] !== 8'd255 || out_data_o[m][0][1] !== exp_q[0]) begin
        fails++; $display("FAIL drop_saturate m%0d got drop=%0d head=%h want 255/%h", m, drop_o[m][0][1], out_data_o[m][0][1], exp_q[0]);
      end
    end
  endtask

  task automatic test_random();
    int wr_pct [4] = '{80, 50, 20, 90};
    int rd_pct [4] = '{20, 50, 80, 90};
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 100; k++) begin
        for (int c = 0; c < D; c++) begin
          logic [7:0] dst;
          in_wr[0][c]   = ($urandom_range(0, 99) < wr_pct[ph]);
          in_data[0][c] = 16'($urandom);
          pop[0][c]     = ($urandom_range(0, 99) < rd_pct[ph]);
          push[0][c]    = ($urandom_range(0, 99) < wr_pct[ph]);
          out_rd[0][c]  = ($urandom_range(0, 99) < rd_pct[ph]);
          case ($urandom_range(0, 2))
            0:       dst = 8'(c);
            1:       dst = 8'hFF;
            default: dst = 8'($urandom);
          endcase
          D_push[0][c] = {dst, 8'($urandom)};
        end
        step();
        for (int m = 0; m < 2; m++) begin
          for (int c = 0; c < D; c++) begin
            logic [3:0] e_flags;
            logic [W-1:0] e_dp, e_od;
            e_flags = {ing_q[m][c].size() != 0, ing_q[m][c].size() == DEP, egr_q[m][c].size() != 0, mis_m[m][c]};
            e_dp = (ing_q[m][c].size() != 0) ? ing_q[m][c][0] : '0;
            e_od = (egr_q[m][c].size() != 0) ? egr_q[m][c][0] : '0;
            tests++;
            if ({pndng_o[m][0][c], in_full_o[m][0][c], out_vld_o[m][0][c], misroute_o[m][0][c]} !== e_flags) begin
              fails++; $display("FAIL rand_flags m%0d ch%0d got %b want %b", m, c,
                {pndng_o[m][0][c], in_full_o[m][0][c], out_vld_o[m][0][c], misroute_o[m][0][c]}, e_flags);
            end
            tests++;
            if (D_pop_o[m][0][c] !== e_dp) begin
              fails++; $display("FAIL rand_D_pop m%0d ch%0d got %h want %h", m, c, D_pop_o[m][0][c], e_dp);
            end
            tests++;
            if (out_data_o[m][0][c] !== e_od) begin
              fails++; $display("FAIL rand_out_data m%0d ch%0d got %h want %h", m, c, out_data_o[m][0][c], e_od);
            end
            tests++;
            if (drop_o[m][0][c] !== 8'(drp_m[m][c])) begin
              fails++; $display("FAIL rand_drop m%0d ch%0d got %0d want %0d", m, c, drop_o[m][0][c], drp_m[m][c]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      in_wr[0][0] = 1'b1; in_data[0][0] = 16'(16'h0500 + i);
      push[0][1]  = 1'b1; D_push[0][1]  = 16'(16'h0100 + i);
      step();
    end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (pndng_o[m] !== '0 || out_vld_o[m] !== '0) begin
        fails++; $display("FAIL midreset_vld m%0d got pndng=%b out_vld=%b want 0/0", m, pndng_o[m], out_vld_o[m]);
      end
      tests++;
      if (drop_o[m] !== '0 || misroute_o[m] !== '0) begin
        fails++; $display("FAIL midreset_cnt m%0d got drop=%h mis=%b want 0/0", m, drop_o[m], misroute_o[m]);
      end
      tests++;
      if (D_pop_o[m] !== '0 || out_data_o[m] !== '0) begin
        fails++; $display("FAIL midreset_data m%0d got %h/%h want 0", m, D_pop_o[m], out_data_o[m]);
      end
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    in_wr[0][3] = 1'b1; in_data[0][3] = 16'h3C3C;
    step();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (pndng_o[m] !== 4'b1000 || D_pop_o[m][0][3] !== 16'h3C3C) begin
        fails++; $display("FAIL postreset_write m%0d got pndng=%b D_pop=%h want 1000/3C3C", m, pndng_o[m], D_pop_o[m][0][3]);
      end
    end
  endtask

  initial begin
    clear_strobes();
    in_data = '0;
    D_push  = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_misroute();
    test_dual_drop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
